ahb_slave_arbiter: RTL
======================

Name: ahb_slave_arbiter

Overview:
- Per-slave AHB arbiter that shares one slave port among MASTER_NUM masters.
- Inputs are each master's decoder hreq bit for this slave, plus that master's htrans.
- Owns the address-phase grant and the data-phase owner pointer, and stalls losing masters.
- Never splits a burst mid-SEQ; a hold counter bounds how long one master can monopolise the slave.
- One instance per slave sits between the decoders and the slave-side address/data muxes.

Parameters:
- MASTER_NUM, 4, number of masters sharing this slave (2..16).
- MAX_HOLD, 16, accepted beats after which the owner is pre-empted at its next NONSEQ if another master requests (>=1).
- MIDX_W, $clog2(MASTER_NUM), width of the master index outputs.

Ports:
- hclk  input  1  clock, rising edge.
- hreset_n  input  1  reset, synchronous, active-low.
- hreq  input  MASTER_NUM  per-master request for this slave (decoder hreq bit).
- htrans  input  MASTER_NUM x htrans_type  per-master htrans, packed, index = master.
- hready  input  1  slave hreadyout; a transfer is accepted on an edge with hready=1.
- hgrant  output  MASTER_NUM  one-hot address-phase owner.
- hmaster  output  MIDX_W  index of hgrant; drives the address/control mux.
- hmaster_data  output  MIDX_W  data-phase owner; drives the hwdata mux and routes hrdata/hresp.
- hsel  output  1  slave select for the current address phase.
- hwait  output  MASTER_NUM  per-master forced wait; OR'd into that master's hready-low.

Behaviour:
- Reset (hreset_n=0 at an edge):
  - hgrant=1 (parked on master 0), hmaster=0, hmaster_data=0.
  - hold_cnt=0, data-phase valid flag dvalid=0.
- Combinational outputs:
  - hsel = hreq[own] & (htrans[own]!=IDLE) & ~preempt.
  - hwait[i] = hreq[i] & (i!=own | preempt).
- Definitions:
  - own = hmaster.
  - others = |(hreq & ~hgrant).
  - preempt = (hold_cnt>=MAX_HOLD) & others & (htrans[own]==NONSEQ).
- preempt masks the owner's NONSEQ, so it is not accepted and the owner retries after regaining grant.
- Switch point: an edge with hready=1 and any of:
  - hreq[own]=0;
  - htrans[own]==IDLE;
  - preempt=1.
- At a switch point: new owner = first i with hreq[i]=1 scanning own+1, own+2, … wrapping modulo MASTER_NUM; own itself is scanned last.
  - If no hreq, grant stays parked on own.
  - If the new owner differs from own, hold_cnt resets to 0.
- Otherwise grant holds. SEQ/BUSY from the owner never causes a switch, so a burst stays intact.
- hready=0 freezes hgrant, hmaster, hmaster_data and hold_cnt.
- hold_cnt increments on each edge with hready=1 and hsel=1 with htrans[own] in {NONSEQ, SEQ}. It saturates at MAX_HOLD; BUSY does not count.
- Data-phase pipeline, on each edge with hready=1:
  - hmaster_data <= hmaster.
  - dvalid <= hsel.
- Latency: a grant change is visible the cycle after the switch edge; data-phase owner lags the address owner by one accepted cycle.
- Simultaneous requests: round-robin from own+1 only; no index-based bias.
- Owner drops hreq mid-burst: treated as a switch point; this is a protocol violation by the master, and the arbiter still never leaves grant undefined.
- Reset mid-burst: all state returns to the reset values on that edge, regardless of hready.
- hgrant is always exactly one-hot. The bench asserts this, plus hsel -> hgrant[own]&hreq[own].

Optional Feature:
- AHB_ARB_FIXED_PRIO_EN.
- Defined: at each switch point the lowest-index requesting master wins.
  - MAX_HOLD pre-emption still applies, but only when a strictly lower-index master requests.
- Undefined: round-robin as above.

Test Plan:
- Reset: hreset_n=0 for 2 cycles with hreq=4'b1111 -> hgrant=0001, hmaster=0, hmaster_data=0, hsel follows master 0.
- Round-robin: hreq=1111, every master does NONSEQ then IDLE, hready=1 -> grant order 0,1,2,3,0.
- Burst integrity: master 1 owns and issues INCR4 (NONSEQ, SEQ×3) while master 2 requests -> hgrant stays 0010 for all 4 beats and moves to 0100 only after master 1's IDLE.
- Wait states: hready=0 for 3 cycles during a master 0 SEQ beat -> hgrant, hmaster_data and hold_cnt frozen; no switch until hready=1.
- Pre-emption: MAX_HOLD=4, master 0 issues back-to-back SINGLE NONSEQs, master 3 requests -> after 4 accepted beats, 5th NONSEQ sees hsel=0 and hwait[0]=1; next cycle hgrant=1000.
- Parking/data routing: hreq=0 after master 2's last beat -> hgrant stays 0100, hsel=0; hmaster_data=2 for exactly the cycle after that beat is accepted.

Source files
------------

// File: rtl/ahb_slave_arbiter.sv
// ============================================================================
// ahb_slave_arbiter: per-slave AHB arbiter (round-robin, burst-safe, hold-bounded)
// Optional macro AHB_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_slave_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int MAX_HOLD   = 16,
    parameter int MIDX_W     = $clog2(MASTER_NUM)
) (
    input  logic                       hclk,
    input  logic                       hreset_n,
    input  logic [MASTER_NUM-1:0]      hreq,
    input  logic [MASTER_NUM-1:0][1:0] htrans,
    input  logic                       hready,
    output logic [MASTER_NUM-1:0]      hgrant,
    output logic [MIDX_W-1:0]          hmaster,
    output logic [MIDX_W-1:0]          hmaster_data,
    output logic                       hsel,
    output logic [MASTER_NUM-1:0]      hwait
);

    localparam int         HOLD_W        = $clog2(MAX_HOLD + 1);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [MIDX_W-1:0]     own_q;
    logic [MIDX_W-1:0]     own_d;
    logic [MIDX_W-1:0]     data_own_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [HOLD_W-1:0]     hold_d;
    logic [MIDX_W-1:0]     w_next_own;
    logic [MASTER_NUM-1:0] w_contend;
    logic [1:0]            w_own_trans;
    logic                  w_own_req;
    logic                  w_hold_full;
    logic                  w_preempt;
    logic                  w_switch;

    assign w_own_trans = htrans[own_q];
    assign w_own_req   = hreq[own_q];
    assign w_hold_full = (hold_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        hgrant        = '0;
        hgrant[own_q] = 1'b1;
    end

`ifdef AHB_ARB_FIXED_PRIO_EN
    // Only a strictly higher-priority (lower-index) requester may pre-empt.
    always_comb begin
        w_contend = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            w_contend[i] = hreq[i] & (MIDX_W'(i) < own_q);
        end
    end

    always_comb begin
        w_next_own = own_q;
        for (int i = MASTER_NUM - 1; i >= 0; i--) begin
            if (hreq[i]) begin
                w_next_own = MIDX_W'(i);
            end
        end
    end
`else
    assign w_contend = hreq & ~hgrant;

    // Scan own+1 .. own+MASTER_NUM so the current owner is considered last.
    always_comb begin
        logic found;
        int   idx;
        found      = 1'b0;
        idx        = 0;
        w_next_own = own_q;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            idx = (int'(own_q) + k) % MASTER_NUM;
            if (!found && hreq[idx]) begin
                w_next_own = MIDX_W'(idx);
                found      = 1'b1;
            end
        end
    end
`endif

    assign w_preempt = w_hold_full & (|w_contend) & (w_own_trans == HTRANS_NONSEQ);
    assign w_switch  = ~w_own_req | (w_own_trans == HTRANS_IDLE) | w_preempt;

    assign hsel         = w_own_req & (w_own_trans != HTRANS_IDLE) & ~w_preempt;
    assign hmaster      = own_q;
    assign hmaster_data = data_own_q;

    always_comb begin
        hwait = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            hwait[i] = hreq[i] & ((MIDX_W'(i) != own_q) | w_preempt);
        end
    end

    assign own_d = (hready && w_switch) ? w_next_own : own_q;

    // NONSEQ and SEQ both have htrans[1] set; BUSY does not count.
    always_comb begin
        hold_d = hold_q;
        if (hready) begin
            if (own_d != own_q) begin
                hold_d = '0;
            end else if (hsel && w_own_trans[1] && !w_hold_full) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            own_q      <= '0;
            data_own_q <= '0;
            hold_q     <= '0;
        end else begin
            own_q  <= own_d;
            hold_q <= hold_d;
            if (hready) begin
                data_own_q <= own_q;
            end
        end
    end

endmodule

`default_nettype wire
